rom_ctrl: RTL and testbench

//  Sequencer/arbiter for the single-port synchronous ROM/RAM array (the KB-sized BRAM holding the
//  +3/esxDOS image). Owns the array's a/d/w pins: boot-time image loading from a byte loader, then

---
 rtl/rom_pkg.sv | 18 +
 rtl/rom_ctrl.sv | 106 ++++++++++
 tb/tb_rom_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_pkg.sv
// Shared definitions for the ROM/RAM array sequencer.
package rom_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } rom_state_e;

    localparam int unsigned BANK_KB      = 16;
    localparam int unsigned BANK_AW      = 14;
    localparam int unsigned READ_LATENCY = 3;

    // Width of a select field for n items, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rom_ctrl.sv
// Owns the single port of the image array: boot-time byte loading, then banked CPU reads
// arbitrated against optional run-time loader writes.
module rom_ctrl
    import rom_pkg::*;
#(
    parameter int unsigned KB        = 64,
    parameter bit          BOOT_LOAD = 1'b1,
    localparam int unsigned BANKS    = KB / BANK_KB,
    localparam int unsigned BW       = clog2_min1(BANKS),
    localparam int unsigned AW       = $clog2(KB * 1024)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           cpu_rd,
    input  logic [13:0]    cpu_a,
    input  logic [BW-1:0]  cpu_bank,
    output logic [7:0]     cpu_q,
    output logic           cpu_valid,
    output logic           cpu_hold,
    input  logic           ldr_req,
    input  logic [AW-1:0]  ldr_a,
    input  logic [7:0]     ldr_d,
    output logic           ldr_ack,
    input  logic           ldr_done,
    input  logic           wr_en,
    output logic [AW-1:0]  rom_a,
    output logic [7:0]     rom_d,
    output logic           rom_w,
    input  logic [7:0]     rom_q
);

    localparam logic [AW:0] LAST = (AW + 1)'(KB * 1024);

    rom_state_e    state_q, state_d;
    logic [AW:0]   count_q;
    logic          rd_v1_q, rd_v2_q;
    logic          run, rd_go, wr_ok, wr_go;
    logic [BW-1:0] bank_mod;
    logic [AW-1:0] rd_addr;

    assign run      = (state_q == ST_RUN);
    assign rd_go    = run && cpu_rd;
    assign wr_ok    = !run || wr_en;
    // A write in flight (rom_w) or an unfinished handshake (ldr_ack) blocks a new accept;
    // a same-cycle CPU read always takes the port first.
    assign wr_go    = wr_ok && ldr_req && !ldr_ack && !rom_w && !rd_go;
    assign bank_mod = BW'(32'(cpu_bank) % BANKS);
    assign rd_addr  = AW'({bank_mod, cpu_a});

    always_comb begin
        state_d = state_q;
        if (!run && (ldr_done || count_q == LAST)) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= BOOT_LOAD ? ST_LOAD : ST_RUN;
            count_q   <= '0;
            rd_v1_q   <= 1'b0;
            rd_v2_q   <= 1'b0;
            rom_a     <= '0;
            rom_d     <= '0;
            rom_w     <= 1'b0;
            ldr_ack   <= 1'b0;
            cpu_q     <= '0;
            cpu_valid <= 1'b0;
            cpu_hold  <= BOOT_LOAD;
        end else begin
            state_q  <= state_d;
            cpu_hold <= (state_d == ST_LOAD);

            rd_v1_q   <= rd_go;
            rd_v2_q   <= rd_v1_q;
            cpu_valid <= rd_v2_q;
            if (rd_v2_q) begin
                cpu_q <= rom_q;
            end

            rom_w <= wr_go;
            if (rd_go) begin
                rom_a <= rd_addr;
            end else if (wr_go) begin
                rom_a <= ldr_a;
                rom_d <= ldr_d;
            end

            if (rom_w) begin
                ldr_ack <= 1'b1;
            end else if (!ldr_req) begin
                ldr_ack <= 1'b0;
            end

            // Terminal count is seen one cycle after the last accept, in step with its ack.
            if (!run) begin
                if (count_q == LAST) begin
                    count_q <= '0;
                end else if (wr_go) begin
                    count_q <= count_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_ctrl.sv
// Directed bench for rom_ctrl: a 64KB instance with a write-first array model, plus a 16KB
// instance used for the counter-wrap and single-bank cases.
module tb_rom_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // 64KB instance
    logic        reset, cpu_rd, cpu_valid, cpu_hold, ldr_req, ldr_ack, ldr_done, wr_en, rom_w;
    logic [13:0] cpu_a;
    logic [1:0]  cpu_bank;
    logic [7:0]  cpu_q, ldr_d, rom_d, rom_q;
    logic [15:0] ldr_a, rom_a;
    logic [7:0]  mem [0:65535];

    rom_ctrl #(.KB(64), .BOOT_LOAD(1'b1)) dut (
        .clock(clock), .reset(reset), .cpu_rd(cpu_rd), .cpu_a(cpu_a), .cpu_bank(cpu_bank),
        .cpu_q(cpu_q), .cpu_valid(cpu_valid), .cpu_hold(cpu_hold), .ldr_req(ldr_req),
        .ldr_a(ldr_a), .ldr_d(ldr_d), .ldr_ack(ldr_ack), .ldr_done(ldr_done), .wr_en(wr_en),
        .rom_a(rom_a), .rom_d(rom_d), .rom_w(rom_w), .rom_q(rom_q)
    );

    always @(posedge clock) begin
        if (rom_w) mem[rom_a] <= rom_d;
        rom_q <= rom_w ? rom_d : mem[rom_a];
    end

    // 16KB instance
    logic        s_reset, s_cpu_rd, s_cpu_valid, s_cpu_hold, s_ldr_req, s_ldr_ack, s_ldr_done;
    logic        s_wr_en, s_rom_w;
    logic [13:0] s_cpu_a, s_ldr_a, s_rom_a;
    logic [0:0]  s_cpu_bank;
    logic [7:0]  s_cpu_q, s_ldr_d, s_rom_d, s_rom_q;

    rom_ctrl #(.KB(16), .BOOT_LOAD(1'b1)) dut_s (
        .clock(clock), .reset(s_reset), .cpu_rd(s_cpu_rd), .cpu_a(s_cpu_a),
        .cpu_bank(s_cpu_bank), .cpu_q(s_cpu_q), .cpu_valid(s_cpu_valid), .cpu_hold(s_cpu_hold),
        .ldr_req(s_ldr_req), .ldr_a(s_ldr_a), .ldr_d(s_ldr_d), .ldr_ack(s_ldr_ack),
        .ldr_done(s_ldr_done), .wr_en(s_wr_en), .rom_a(s_rom_a), .rom_d(s_rom_d),
        .rom_w(s_rom_w), .rom_q(s_rom_q)
    );

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge with the port idle; one full 4-phase write on the 64KB instance.
    task automatic wr1(input logic [15:0] a, input logic [7:0] d, input string tag);
        ldr_a = a; ldr_d = d; ldr_req = 1'b1;
        @(negedge clock);
        chk({tag, ".rom_w"}, 32'(rom_w), 1);
        chk({tag, ".rom_a"}, 32'(rom_a), 32'(a));
        chk({tag, ".rom_d"}, 32'(rom_d), 32'(d));
        @(negedge clock);
        chk({tag, ".rom_w_end"}, 32'(rom_w), 0);
        chk({tag, ".ack"}, 32'(ldr_ack), 1);
        ldr_req = 1'b0;
        @(negedge clock);
        chk({tag, ".ack_drop"}, 32'(ldr_ack), 0);
    endtask

    logic [7:0] burst_exp [0:7] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        int bad, waited, to_cnt, early, wcnt;
        reset = 1'b1; cpu_rd = 1'b0; cpu_a = '0; cpu_bank = '0; ldr_req = 1'b0;
        ldr_a = '0; ldr_d = '0; ldr_done = 1'b0; wr_en = 1'b0;
        s_reset = 1'b1; s_cpu_rd = 1'b0; s_cpu_a = '0; s_cpu_bank = '0; s_ldr_req = 1'b0;
        s_ldr_a = '0; s_ldr_d = '0; s_ldr_done = 1'b0; s_wr_en = 1'b0; s_rom_q = 8'h5C;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst.rom_a", 32'(rom_a), 0);
        chk("rst.rom_d", 32'(rom_d), 0);
        chk("rst.rom_w", 32'(rom_w), 0);
        chk("rst.ldr_ack", 32'(ldr_ack), 0);
        chk("rst.cpu_q", 32'(cpu_q), 0);
        chk("rst.cpu_valid", 32'(cpu_valid), 0);
        chk("rst.cpu_hold", 32'(cpu_hold), 1);
        reset = 1'b0;
        @(negedge clock);
        chk("load.hold", 32'(cpu_hold), 1);

        // CPU reads are ignored while loading
        cpu_rd = 1'b1;
        @(negedge clock);
        cpu_rd = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clock);
            if (cpu_valid !== 1'b0) bad++;
        end
        chk("load.rd_ignored", 32'(bad), 0);

        // Boot image
        wr1(16'h0000, 8'hA5, "boot0");
        wr1(16'h0001, 8'h5A, "boot1");
        wr1(16'h0002, 8'hC3, "boot2");
        wr1(16'h0003, 8'h3C, "boot3");
        ldr_done = 1'b1;
        chk("done.hold_before", 32'(cpu_hold), 1);
        @(negedge clock);
        ldr_done = 1'b0;
        chk("done.hold_after", 32'(cpu_hold), 0);

        // Run-time writes used by later reads
        wr_en = 1'b1;
        wr1(16'h8010, 8'h77, "rw8010");
        wr1(16'h0004, 8'h11, "rw4");
        wr1(16'h0005, 8'h22, "rw5");
        wr1(16'h0006, 8'h33, "rw6");
        wr1(16'h0007, 8'h44, "rw7");
        wr_en = 1'b0;

        // Single banked read, latency 3
        cpu_rd = 1'b1; cpu_bank = 2'd2; cpu_a = 14'h0010;
        @(negedge clock);
        cpu_rd = 1'b0;
        chk("rd.rom_a", 32'(rom_a), 32'h8010);
        chk("rd.rom_w", 32'(rom_w), 0);
        chk("rd.valid_n1", 32'(cpu_valid), 0);
        @(negedge clock);
        chk("rd.valid_n2", 32'(cpu_valid), 0);
        @(negedge clock);
        chk("rd.valid_n3", 32'(cpu_valid), 1);
        chk("rd.q", 32'(cpu_q), 32'h77);
        @(negedge clock);
        chk("rd.valid_n4", 32'(cpu_valid), 0);

        // Back-to-back reads of 0..7
        cpu_bank = 2'd0;
        for (int c = 0; c < 12; c++) begin
            cpu_rd = (c < 8);
            cpu_a  = 14'(c);
            if (c >= 3 && c < 11) begin
                chk($sformatf("burst.valid%0d", c), 32'(cpu_valid), 1);
                chk($sformatf("burst.q%0d", c - 3), 32'(cpu_q), 32'(burst_exp[c - 3]));
            end else begin
                chk($sformatf("burst.valid%0d", c), 32'(cpu_valid), 0);
            end
            @(negedge clock);
        end
        cpu_rd = 1'b0;

        // Read wins over a same-cycle write; write follows in the next free cycle
        wr_en = 1'b1;
        ldr_req = 1'b1; ldr_a = 16'h0100; ldr_d = 8'hEE;
        cpu_rd = 1'b1; cpu_bank = 2'd0; cpu_a = 14'h0000;
        @(negedge clock);
        cpu_rd = 1'b0;
        chk("arb.rd_first_a", 32'(rom_a), 0);
        chk("arb.rd_first_w", 32'(rom_w), 0);
        @(negedge clock);
        chk("arb.wr_w", 32'(rom_w), 1);
        chk("arb.wr_a", 32'(rom_a), 32'h0100);
        chk("arb.wr_d", 32'(rom_d), 32'hEE);
        @(negedge clock);
        chk("arb.ack", 32'(ldr_ack), 1);
        chk("arb.rd_valid", 32'(cpu_valid), 1);
        chk("arb.rd_q", 32'(cpu_q), 32'hA5);
        ldr_req = 1'b0;
        @(negedge clock);
        chk("arb.ack_drop", 32'(ldr_ack), 0);

        // Loader stalls in RUN with writes disabled
        wr_en = 1'b0;
        ldr_req = 1'b1; ldr_a = 16'h0200; ldr_d = 8'h11;
        bad = 0;
        repeat (20) begin
            @(negedge clock);
            if (rom_w !== 1'b0 || ldr_ack !== 1'b0) bad++;
        end
        chk("wr_dis.stall", 32'(bad), 0);
        chk("wr_dis.rom_d_hold", 32'(rom_d), 32'hEE);
        ldr_req = 1'b0;

        // Deferred write landed in the array
        cpu_rd = 1'b1; cpu_a = 14'h0100;
        @(negedge clock);
        cpu_rd = 1'b0;
        repeat (2) @(negedge clock);
        chk("arb.readback_valid", 32'(cpu_valid), 1);
        chk("arb.readback_q", 32'(cpu_q), 32'hEE);

        // Reset in the middle of a load handshake
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst2.hold", 32'(cpu_hold), 1);
        ldr_req = 1'b1; ldr_a = 16'h0004; ldr_d = 8'h66;
        @(negedge clock);
        @(negedge clock);
        chk("abort.ack_up", 32'(ldr_ack), 1);
        reset = 1'b1;
        @(negedge clock);
        chk("abort.ack", 32'(ldr_ack), 0);
        chk("abort.rom_w", 32'(rom_w), 0);
        chk("abort.hold", 32'(cpu_hold), 1);
        chk("abort.rom_a", 32'(rom_a), 0);
        ldr_req = 1'b0; reset = 1'b0;
        @(negedge clock);
        chk("abort.still_load", 32'(cpu_hold), 1);
        ldr_done = 1'b1;
        @(negedge clock);
        ldr_done = 1'b0;
        cpu_rd = 1'b1; cpu_a = 14'h0004;
        @(negedge clock);
        cpu_rd = 1'b0;
        repeat (2) @(negedge clock);
        chk("abort.image_kept", 32'(cpu_q), 32'h66);

        // Counter wrap on the 16KB instance: RUN after 16384 writes, no ldr_done
        s_reset = 1'b0;
        @(negedge clock);
        to_cnt = 0; early = 0; wcnt = 0;
        for (int i = 0; i < 16384; i++) begin
            s_ldr_a = 14'(i); s_ldr_d = 8'(i); s_ldr_req = 1'b1;
            waited = 0;
            do begin
                @(negedge clock);
                if (s_rom_w) wcnt++;
                waited++;
            end while (!s_ldr_ack && waited < 8);
            if (!s_ldr_ack) to_cnt++;
            if (i < 16383 && !s_cpu_hold) early++;
            s_ldr_req = 1'b0;
            waited = 0;
            do begin
                @(negedge clock);
                if (s_rom_w) wcnt++;
                waited++;
            end while (s_ldr_ack && waited < 8);
            if (s_ldr_ack) to_cnt++;
            if (to_cnt > 4) break;
        end
        chk("wrap.timeouts", 32'(to_cnt), 0);
        chk("wrap.early_run", 32'(early), 0);
        chk("wrap.writes", 32'(wcnt), 16384);
        chk("wrap.hold", 32'(s_cpu_hold), 0);

        // Single bank: bank 1 wraps to bank 0
        s_cpu_rd = 1'b1; s_cpu_bank = 1'b1; s_cpu_a = 14'h0123;
        @(negedge clock);
        s_cpu_rd = 1'b0;
        chk("wrap.bank_mod", 32'(s_rom_a), 32'h0123);
        repeat (2) @(negedge clock);
        chk("wrap.rd_valid", 32'(s_cpu_valid), 1);
        chk("wrap.rd_q", 32'(s_cpu_q), 32'h5C);

        // In RUN with writes disabled the loader is no longer served
        s_ldr_req = 1'b1;
        repeat (5) @(negedge clock);
        chk("wrap.run_no_ack", 32'(s_ldr_ack), 0);
        s_ldr_req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
